xbar_egress_buffer: RTL

- Sits directly downstream of the Benes permutation network and consumes its SIZE-lane output vector.
- The network has a fixed pipeline latency and no stall input. This block tracks issued vectors through that latency with a valid delay line.
- It captures each vector as it emerges into a DEPTH-entry FIFO and presents it to the consumer with valid/ready backpressure.
- It grants issue credit upstream so the FIFO can never overflow.

---
 rtl/xbar_egress_buffer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/xbar_egress_buffer.sv
// xbar_egress_buffer
// Egress stage behind the Benes permutation network. A valid delay line
// follows each issued vector through the fixed network latency. Arriving
// vectors are captured into a small FIFO that drains with valid/ready.
// Upstream issue credit covers both buffered and in-flight vectors, so
// the FIFO cannot overflow while the credit is honoured.
module xbar_egress_buffer #(
  parameter int SIZE          = 32,
  parameter int DWIDTH        = 16,
  parameter int LATENCY       = 8,
  parameter int DEPTH         = 4,
  // When set, issue ignores in_ready. This exists only so a bench can
  // provoke the full-FIFO corner cases; leave at 0 in real use.
  parameter bit CREDIT_BYPASS = 1'b0
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SIZE*DWIDTH-1:0]       xbar_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SIZE*DWIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(LATENCY+2)-1:0] inflight,
  output logic                         overflow_err
);

  localparam int DW = SIZE * DWIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 2);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic          issue;
  logic          arrive;
  logic          pop;
  logic          wr_en;
  logic [SW-1:0] occ;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [DW-1:0] mem [DEPTH];

  // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_adv(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit counts vectors already buffered plus those still in the network.
  // It looks at registered state only, so a pop this cycle frees credit
  // next cycle. Flush withholds credit for its own cycle.
  assign occ      = SW'(count) + SW'(inflight);
  assign in_ready = ~flush & (occ < SW'(DEPTH));
  assign issue    = in_valid & (in_ready | CREDIT_BYPASS);

  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];
  assign pop       = out_valid & out_ready;

  // An arrival is stored unless flushed, or the FIFO is full with no pop.
  assign wr_en = arrive & ~flush & ((count != FULL) | pop);

  generate
    if (LATENCY == 0) begin : g_no_lat
      // Combinational network: the vector is available in its issue cycle.
      assign arrive   = issue;
      assign inflight = '0;
    end else begin : g_lat
      logic [LATENCY-1:0] vld_dly;

      // Valid delay line mirroring the network's pipeline stages.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          vld_dly <= '0;
        end else if (flush) begin
          vld_dly <= '0;
        end else begin
          vld_dly[0] <= issue;
          for (int k = 1; k < LATENCY; k++) begin
            vld_dly[k] <= vld_dly[k-1];
          end
        end
      end

      assign arrive = vld_dly[LATENCY-1];

      // Running popcount of the delay line, kept as a counter for timing.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          inflight <= '0;
        end else if (flush) begin
          inflight <= '0;
        end else begin
          inflight <= inflight + IW'(issue) - IW'(arrive);
        end
      end
    end
  endgenerate

  // FIFO pointers and occupancy; flush returns everything to empty.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= ptr_adv(wptr);
      end
      if (pop) begin
        rptr <= ptr_adv(rptr);
      end
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  // Vector storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wptr] <= xbar_out;
    end
  end

  // Sticky flag for an arrival that found the FIFO full and was dropped.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_err <= 1'b0;
    end else if (arrive & ~flush & ~pop & (count == FULL)) begin
      overflow_err <= 1'b1;
    end
  end

endmodule
